color_filter_pipe: RTL

Parametrised, pipelined per-pixel colour filter for the image DSP path. It replaces the fixed single-mode red filter. It takes one packed 3x3 RGB neighbourhood per cycle and applies a runtime-selected mode: passthrough, invert, grayscale, sharpen or box blur. A per-channel output mask is applied after the mode. The block sits between the line-buffer/window generator and the VGA pixel output, and carries a delay-matched copy of the original centre pixel.

---
 rtl/color_filter_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/color_filter_pipe.sv
// Three-stage per-pixel colour filter over a packed 3x3 RGB window.
// Modes: pass, invert, grayscale, sharpen, box blur; per-channel mask on the result.
module color_filter_pipe #(
  parameter int CW  = 4,
  parameter int LAT = 3,
  localparam int PW = 3 * CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            in_valid,
  input  logic [9*PW-1:0] color_data,
  input  logic [2:0]      mode,
  input  logic [2:0]      chan_mask,
  output logic            out_valid,
  output logic [PW-1:0]   filter_rgb_out,
  output logic [PW-1:0]   original_out
);

  // in_valid/out_valid only qualify data; there is no ready. en is the single
  // stall control and freezes every stage (data and valid bits) together.

  localparam int SW = CW + 4;   // unsigned sum of up to 9 channel values
  localparam int GW = CW + 8;   // one grayscale product term
  localparam int RW = CW + 12;  // signed result, wide enough for 513*MAX

  localparam logic [CW-1:0]        MAX    = {CW{1'b1}};
  localparam logic signed [RW-1:0] MAX_E  = RW'(MAX);
  localparam logic signed [RW-1:0] ZERO_E = '0;
  localparam logic signed [RW-1:0] K5     = RW'(5);
  localparam logic signed [RW-1:0] K57    = RW'(57);

  localparam logic [2:0] M_INVERT  = 3'd1;
  localparam logic [2:0] M_GRAY    = 3'd2;
  localparam logic [2:0] M_SHARPEN = 3'd3;
  localparam logic [2:0] M_BLUR    = 3'd4;

  // ---------------- Stage 1: unpack and form partial terms ----------------
  // win[slot][channel]; slot 0 centre, 1 left, 2 right, 3 up, 4 down, 5..8 diagonals.
  logic [CW-1:0] win [9][3];

  always_comb begin
    for (int s = 0; s < 9; s++) begin
      for (int ch = 0; ch < 3; ch++) begin
        win[s][ch] = color_data[(8 - s) * PW + (2 - ch) * CW +: CW];
      end
    end
  end

  logic [SW-1:0] n4_d [3];
  logic [SW-1:0] s9_d [3];
  logic [GW-1:0] gp_d [3];

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      n4_d[ch] = SW'(win[1][ch]) + SW'(win[2][ch]) + SW'(win[3][ch]) + SW'(win[4][ch]);
      s9_d[ch] = '0;
      for (int s = 0; s < 9; s++) begin
        s9_d[ch] = s9_d[ch] + SW'(win[s][ch]);
      end
    end
    gp_d[0] = GW'(win[0][0]) * GW'(77);
    gp_d[1] = GW'(win[0][1]) * GW'(150);
    gp_d[2] = GW'(win[0][2]) * GW'(29);
  end

  logic          s1_valid;
  logic [2:0]    s1_mode;
  logic [2:0]    s1_mask;
  logic [PW-1:0] s1_orig;
  logic [CW-1:0] s1_c  [3];
  logic [SW-1:0] s1_n4 [3];
  logic [SW-1:0] s1_s9 [3];
  logic [GW-1:0] s1_gp [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_mask  <= '0;
      s1_orig  <= '0;
      for (int ch = 0; ch < 3; ch++) begin
        s1_c[ch]  <= '0;
        s1_n4[ch] <= '0;
        s1_s9[ch] <= '0;
        s1_gp[ch] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= mode;
      s1_mask  <= chan_mask;
      s1_orig  <= color_data[9*PW-1 -: PW];
      for (int ch = 0; ch < 3; ch++) begin
        s1_c[ch]  <= win[0][ch];
        s1_n4[ch] <= n4_d[ch];
        s1_s9[ch] <= s9_d[ch];
        s1_gp[ch] <= gp_d[ch];
      end
    end
  end

  // ---------------- Stage 2: combine terms for the pixel's own mode ----------------
  logic signed [RW-1:0] res_d [3];
  logic signed [RW-1:0] gray_d;
  logic signed [RW-1:0] c_e;
  logic signed [RW-1:0] n4_e;
  logic signed [RW-1:0] s9_e;

  always_comb begin
    gray_d = (RW'(s1_gp[0]) + RW'(s1_gp[1]) + RW'(s1_gp[2])) >> 8;
    c_e    = '0;
    n4_e   = '0;
    s9_e   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c_e  = RW'(s1_c[ch]);
      n4_e = RW'(s1_n4[ch]);
      s9_e = RW'(s1_s9[ch]);
      case (s1_mode)
        M_INVERT:  res_d[ch] = MAX_E - c_e;
        M_GRAY:    res_d[ch] = gray_d;
        M_SHARPEN: res_d[ch] = K5 * c_e - n4_e;
        M_BLUR:    res_d[ch] = (s9_e * K57) >>> 9;
        default:   res_d[ch] = c_e;
      endcase
    end
  end

  logic                 s2_valid;
  logic [2:0]           s2_mask;
  logic [PW-1:0]        s2_orig;
  logic signed [RW-1:0] s2_res [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_mask  <= '0;
      s2_orig  <= '0;
      for (int ch = 0; ch < 3; ch++) begin
        s2_res[ch] <= '0;
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_mask  <= s1_mask;
      s2_orig  <= s1_orig;
      for (int ch = 0; ch < 3; ch++) begin
        s2_res[ch] <= res_d[ch];
      end
    end
  end

  // ---------------- Stage 3: saturate, mask, register outputs ----------------
  logic [CW-1:0] sat_d [3];
  logic [PW-1:0] filt_d;

  always_comb begin
    filt_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (s2_res[ch] < ZERO_E) begin
        sat_d[ch] = '0;
      end else if (s2_res[ch] > MAX_E) begin
        sat_d[ch] = MAX;
      end else begin
        sat_d[ch] = s2_res[ch][CW-1:0];
      end
      filt_d[(2 - ch) * CW +: CW] = s2_mask[2 - ch] ? sat_d[ch] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      filter_rgb_out <= '0;
      original_out   <= '0;
    end else if (en) begin
      out_valid      <= s2_valid;
      filter_rgb_out <= filt_d;
      original_out   <= s2_orig;
    end
  end

  // Latency is structural: three register stages above.
  lat_fixed: assert property (@(posedge clk) LAT == 3)
    else $error("color_filter_pipe: LAT must be 3");

endmodule
